// File: rtl/controle_pagamento.sv
// Vending-machine payment controller: accumulates decoded banknote credit against a
// latched price, then dispenses with change, or refunds on cancel or idle timeout.
module controle_pagamento #(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int LARGURA_TIMER  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic [7:0] preco,
  input  logic [2:0] entrada_nota,
  input  logic       nota_valida,
  input  logic       cancelar,
  output logic [8:0] credito,
  output logic       liberar,
  output logic [8:0] troco,
  output logic       troco_valido,
  output logic       nota_rejeitada,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'b000,
    COLETA  = 3'b001,
    LIBERA  = 3'b010,
    TROCO   = 3'b011,
    DEVOLVE = 3'b100
  } estado_t;

  localparam logic [LARGURA_TIMER-1:0] TIMER_LIMITE = LARGURA_TIMER'(TIMEOUT_CICLOS - 1);

  estado_t                  estado_q;
  logic [8:0]               credito_q;
  logic [8:0]               troco_q;
  logic [7:0]               preco_q;
  logic [LARGURA_TIMER-1:0] timer_q;
  logic                     liberar_q;
  logic                     troco_valido_q;
  logic                     nota_rejeitada_q;
  logic [8:0]               credito_d;
  logic [8:0]               preco_ext;

  function automatic logic [8:0] decodifica(input logic [2:0] codigo);
    case (codigo)
      3'b001:  decodifica = 9'd2;
      3'b010:  decodifica = 9'd5;
      3'b011:  decodifica = 9'd10;
      3'b100:  decodifica = 9'd20;
      3'b101:  decodifica = 9'd50;
      3'b110:  decodifica = 9'd100;
      3'b111:  decodifica = 9'd200;
      default: decodifica = 9'd0;
    endcase
  endfunction

  // Max credit is 254 + 200 = 454, so the 9-bit sum cannot wrap.
  assign credito_d = credito_q + decodifica(entrada_nota);
  assign preco_ext = {1'b0, preco_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q         <= OCIOSO;
      credito_q        <= '0;
      troco_q          <= '0;
      preco_q          <= '0;
      timer_q          <= '0;
      liberar_q        <= 1'b0;
      troco_valido_q   <= 1'b0;
      nota_rejeitada_q <= 1'b0;
    end else begin
      liberar_q        <= 1'b0;
      troco_valido_q   <= 1'b0;
      nota_rejeitada_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          nota_rejeitada_q <= nota_valida;
          if (iniciar) begin
            preco_q   <= preco;
            credito_q <= '0;
            timer_q   <= '0;
            estado_q  <= COLETA;
          end
        end
        COLETA: begin
          if (cancelar) begin
            nota_rejeitada_q <= nota_valida;
            troco_q          <= credito_q;
            troco_valido_q   <= 1'b1;
            estado_q         <= DEVOLVE;
          end else if (nota_valida) begin
            credito_q <= credito_d;
            timer_q   <= '0;
            if (credito_d >= preco_ext) begin
              liberar_q <= 1'b1;
              estado_q  <= LIBERA;
            end
          end else if (credito_q >= preco_ext) begin
            // Only reachable with a zero price: dispense without any note.
            liberar_q <= 1'b1;
            estado_q  <= LIBERA;
          end else if (timer_q == TIMER_LIMITE) begin
            troco_q        <= credito_q;
            troco_valido_q <= 1'b1;
            estado_q       <= DEVOLVE;
          end else begin
            timer_q <= timer_q + LARGURA_TIMER'(1);
          end
        end
        LIBERA: begin
          nota_rejeitada_q <= nota_valida;
          if (credito_q > preco_ext) begin
            troco_q        <= credito_q - preco_ext;
            troco_valido_q <= 1'b1;
            estado_q       <= TROCO;
          end else begin
            credito_q <= '0;
            estado_q  <= OCIOSO;
          end
        end
        TROCO, DEVOLVE: begin
          nota_rejeitada_q <= nota_valida;
          credito_q        <= '0;
          estado_q         <= OCIOSO;
        end
        default: begin
          credito_q <= '0;
          estado_q  <= OCIOSO;
        end
      endcase
    end
  end

  assign credito        = credito_q;
  assign liberar        = liberar_q;
  assign troco          = troco_q;
  assign troco_valido   = troco_valido_q;
  assign nota_rejeitada = nota_rejeitada_q;
  assign estado         = estado_q;

endmodule

// File: doc/controle_pagamento.md
Name: controle_pagamento

Overview:
Sequential payment controller for the vending-machine datapath. It accepts one banknote code per valid pulse and decodes it to a value in reais. It accumulates credit against a latched product price, then sequences dispense and change, or a full refund on cancel or timeout. It sits between the note-acceptor front end and the dispense/change actuators.

Parameters:
TIMEOUT_CICLOS, 1000, idle cycles allowed in COLETA before automatic refund (must be ≥2)
LARGURA_TIMER, 10, width of the timeout counter (must hold TIMEOUT_CICLOS-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
iniciar  input  1  one-cycle pulse: start a purchase at preco
preco  input  8  product price in reais, sampled only when iniciar is accepted
entrada_nota  input  3  note code: 000=0, 001=2, 010=5, 011=10, 100=20, 101=50, 110=100, 111=200
nota_valida  input  1  one-cycle pulse: entrada_nota is valid this cycle
cancelar  input  1  one-cycle pulse: buyer abort
credito  output  9  accumulated credit in reais
liberar  output  1  one-cycle pulse: dispense product
troco  output  9  change or refund amount, valid while troco_valido=1
troco_valido  output  1  one-cycle pulse qualifying troco
nota_rejeitada  output  1  one-cycle pulse: note offered outside COLETA
estado  output  3  current state code, for debug/display

Behaviour:
- Reset (rst_n=0, async): estado=OCIOSO, credito=0, troco=0, liberar=0, troco_valido=0, nota_rejeitada=0, latched price=0, timer=0.
- States and codes: OCIOSO=000, COLETA=001, LIBERA=010, TROCO=011, DEVOLVE=100. Codes 101–111 are unused and go to OCIOSO on the next edge with credito cleared.
- Note decode is combinational: 000→0, 001→2, 010→5, 011→10, 100→20, 101→50, 110→100, 111→200.
- OCIOSO:
  - iniciar=1 latches preco, clears credito and timer, and moves to COLETA.
  - nota_valida=1 pulses nota_rejeitada the next cycle; credito is unchanged.
  - cancelar is ignored.
- COLETA, priority cancelar > nota_valida > timeout:
  - cancelar=1 → DEVOLVE. A simultaneous note is discarded and nota_rejeitada pulses.
  - nota_valida=1:
    - credito += decoded value; timer cleared.
    - If the new credito ≥ latched price → LIBERA.
    - Code 000 adds 0 but still clears the timer.
  - No event: timer increments. At timer == TIMEOUT_CICLOS-1 → DEVOLVE.
  - Price 0: the first clock in COLETA goes directly to LIBERA with credito=0.
  - iniciar is ignored in every state except OCIOSO.
- Width rule: credito never exceeds 254+200=454, so 9 bits never overflow and no saturation is needed.
- LIBERA:
  - liberar=1 for exactly one cycle while in this state.
  - Next state is TROCO if credito > price, else OCIOSO with credito cleared.
- TROCO:
  - troco = credito − price; troco_valido=1 for one cycle.
  - Next: OCIOSO with credito=0.
- DEVOLVE:
  - troco = credito; troco_valido=1 for one cycle, even if credito=0 (amount 0).
  - Next: OCIOSO with credito=0.
- Notes arriving in LIBERA, TROCO or DEVOLVE: nota_rejeitada pulses and credito is unchanged.
- Output timing:
  - All outputs are registered. liberar and troco_valido are asserted in the cycle the FSM occupies LIBERA, TROCO or DEVOLVE.
  - troco holds its last value between pulses; it is cleared only by reset.
- Latency: qualifying note edge → LIBERA is 1 cycle; LIBERA → troco_valido is 1 cycle.
- Reset mid-transaction: credit is lost and no refund pulse is issued. This is accepted behaviour.

Test Plan:
- Exact payment: reset, iniciar with preco=15, notes 011 then 010 → credito 10, then 15; liberar pulses once; no troco_valido; back to OCIOSO with credito=0.
- Overpayment: preco=7, note 111 → credito=200, liberar, next cycle troco=193 with troco_valido=1, then OCIOSO.
- Cancel: preco=100, notes 101 and 100 (credito=70), then cancelar → DEVOLVE, troco=70, no liberar. Repeat with a note in the same cycle as cancelar → troco=70 and nota_rejeitada=1.
- Timeout (TIMEOUT_CICLOS=8): preco=50, note 001, then idle → DEVOLVE exactly 8 cycles after the note, troco=2.
- Rejection and max credit: note in OCIOSO → nota_rejeitada=1 with credito unchanged; preco=255 with notes 111, 101, 001, 010 → credito=257 on the fourth note, liberar, troco=2.
- Async reset: assert rst_n=0 mid-COLETA between clock edges → estado=000 and credito=0 immediately with no clock; later iniciar works normally.
